counter_sweep_ctrl: RTL and testbench

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

---
 rtl/counter_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for an external up/down counter.
// A job seeks the counter to lo, then sweeps lo -> hi -> lo repeatedly,
// holding dwell+1 cycles at each bound, for n_sweeps sweeps (0 = until stop).
module counter_sweep_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [3:0]   dwell,
  input  logic [3:0]   n_sweeps,
  input  logic [W-1:0] count,
  output logic         cnt_en,
  output logic         cnt_dir,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [3:0]   sweeps
);

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    UP,
    DWELL_HI,
    DOWN,
    DWELL_LO
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state;
  state_t       state_d;
  logic [W-1:0] lo_q;
  logic [W-1:0] hi_q;
  logic [3:0]   dwell_q;
  logic [3:0]   n_q;
  logic [3:0]   dwell_cnt;
  logic [3:0]   sweeps_inc;
  logic         job_load;
  logic         dwell_load;
  logic         sweep_step;
  logic         done_d;
  logic         err_d;

  assign sweeps_inc = (sweeps == 4'hF) ? sweeps : sweeps + 4'd1;
  assign busy       = (state != IDLE);

  // Next-state, counter control decode and event strobes
  always_comb begin
    state_d    = state;
    cnt_en     = 1'b0;
    cnt_dir    = 1'b0;
    job_load   = 1'b0;
    dwell_load = 1'b0;
    sweep_step = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (lo < hi) begin
            job_load = 1'b1;
            state_d  = SEEK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEEK: begin
        cnt_en  = (count != lo_q);
        cnt_dir = (count < lo_q);
        if (count == lo_q) state_d = UP;
      end
      UP: begin
        cnt_en  = 1'b1;
        cnt_dir = 1'b1;
        // Leave one step early so the counter lands exactly on hi.
        if (count == hi_q - ONE) begin
          state_d    = DWELL_HI;
          dwell_load = 1'b1;
        end
      end
      DWELL_HI: begin
        if (dwell_cnt == '0) state_d = DOWN;
      end
      DOWN: begin
        cnt_en = 1'b1;
        if (count == lo_q + ONE) begin
          sweep_step = 1'b1;
          if ((n_q != '0) && (sweeps_inc == n_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = DWELL_LO;
            dwell_load = 1'b1;
          end
        end
      end
      DWELL_LO: begin
        if (dwell_cnt == '0) state_d = UP;
      end
      default: state_d = IDLE;
    endcase
    // Stop overrides every transition and suppresses completion side effects.
    if (stop && (state != IDLE)) begin
      state_d    = IDLE;
      dwell_load = 1'b0;
      sweep_step = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Job shadow copies, taken only when a job is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= '0;
      hi_q    <= '0;
      dwell_q <= '0;
      n_q     <= '0;
    end else if (job_load) begin
      lo_q    <= lo;
      hi_q    <= hi;
      dwell_q <= dwell;
      n_q     <= n_sweeps;
    end
  end

  // Dwell down-counter: loaded on bound arrival, exit when it reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if (dwell_load) begin
      dwell_cnt <= dwell_q;
    end else if (((state == DWELL_HI) || (state == DWELL_LO)) && (dwell_cnt != '0)) begin
      dwell_cnt <= dwell_cnt - 4'd1;
    end
  end

  // Completed-sweep counter and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweeps <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (job_load)        sweeps <= '0;
      else if (sweep_step) sweeps <= sweeps_inc;
      done <= done_d;
      err  <= err_d;
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: closes the loop with a behavioural up/down
// counter and compares every cycle of a job against an expected trace.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] dwell;
  logic [3:0] n_sweeps;
  logic [3:0] count;
  logic       cnt_en;
  logic       cnt_dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] sweeps;

  logic       ld;
  logic [3:0] ldv;

  int n_vec;
  int n_mis;
  int model_sw;
  int model_cnt;

  typedef struct packed {
    logic       busy;
    logic       en;
    logic       dir;
    logic       done;
    logic       err;
    logic [3:0] sw;
    logic [3:0] cnt;
  } rec_t;

  typedef struct {
    int cnt0;
    int lo;
    int hi;
    int dw;
    int n;
    int stop_sw;
    int noise;
    int exp_len;
    int exp_sw;
  } vec_t;

  rec_t exp_q[$];
  vec_t tv[7];

  counter_sweep_ctrl #(.W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .lo       (lo),
    .hi       (hi),
    .dwell    (dwell),
    .n_sweeps (n_sweeps),
    .count    (count),
    .cnt_en   (cnt_en),
    .cnt_dir  (cnt_dir),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .sweeps   (sweeps)
  );

  always #5 clk = ~clk;

  // The controlled counter, with a bench-side preload between jobs
  always @(posedge clk) begin
    if (ld)          count <= ldv;
    else if (cnt_en) count <= cnt_dir ? count + 4'd1 : count - 4'd1;
  end

  function automatic rec_t mk(int b, int e, int d, int dn, int er, int s, int c);
    rec_t r;
    r.busy = b[0];
    r.en   = e[0];
    r.dir  = d[0];
    r.done = dn[0];
    r.err  = er[0];
    r.sw   = s[3:0];
    r.cnt  = c[3:0];
    return r;
  endfunction

  // Expected per-cycle trace of a job, starting with the first cycle after start
  task automatic build(int c0, int lo_i, int hi_i, int dw, int n, int stop_idx);
    int   c;
    int   s;
    int   loops;
    rec_t r;
    exp_q.delete();
    c = c0;
    s = model_sw * 0;
    while (c != lo_i) begin
      exp_q.push_back(mk(1, 1, (c < lo_i) ? 1 : 0, 0, 0, s, c));
      c += (c < lo_i) ? 1 : -1;
    end
    exp_q.push_back(mk(1, 0, 0, 0, 0, s, c));
    loops = (n == 0) ? 4 : n;
    for (int k = 1; k <= loops; k++) begin
      for (int t = 0; t < hi_i - lo_i; t++) begin
        exp_q.push_back(mk(1, 1, 1, 0, 0, s, c));
        c++;
      end
      for (int t = 0; t <= dw; t++) exp_q.push_back(mk(1, 0, 0, 0, 0, s, c));
      for (int t = 0; t < hi_i - lo_i; t++) begin
        exp_q.push_back(mk(1, 1, 0, 0, 0, s, c));
        c--;
      end
      s = (s < 15) ? s + 1 : 15;
      if (n != 0 && k == n) exp_q.push_back(mk(0, 0, 0, 1, 0, s, c));
      else for (int t = 0; t <= dw; t++) exp_q.push_back(mk(1, 0, 0, 0, 0, s, c));
    end
    if (stop_idx >= 0 && stop_idx < exp_q.size()) begin
      r = exp_q[stop_idx];
      s = int'(r.sw);
      c = int'(r.cnt) + (r.en ? (r.dir ? 1 : -1) : 0);
      while (exp_q.size() > stop_idx + 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 0, 0, 0, 0, s, c));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, s, c));
  endtask

  task automatic check(string name, int idx, rec_t e);
    n_vec++;
    if (busy !== e.busy || cnt_en !== e.en || cnt_dir !== e.dir || done !== e.done ||
        err !== e.err || sweeps !== e.sw || count !== e.cnt) begin
      n_mis++;
      $display("FAIL %s[%0d]: got busy=%b en=%b dir=%b done=%b err=%b sweeps=%0d count=%0d, expected busy=%b en=%b dir=%b done=%b err=%b sweeps=%0d count=%0d",
               name, idx, busy, cnt_en, cnt_dir, done, err, sweeps, count,
               e.busy, e.en, e.dir, e.done, e.err, e.sw, e.cnt);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Preload the counter, start a job, then compare each cycle of its trace
  task automatic run_job(int cnt0, int lo_i, int hi_i, int dw, int n, int stop_idx,
                         int noise, int rst_idx, output int busy_cycles, output int sw_final);
    build(cnt0, lo_i, hi_i, dw, n, stop_idx);
    busy_cycles = 0;
    @(posedge clk); #1;
    ld = 1'b1; ldv = cnt0[3:0]; start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    ld = 1'b0; start = 1'b1;
    lo = lo_i[3:0]; hi = hi_i[3:0]; dwell = dw[3:0]; n_sweeps = n[3:0];
    @(negedge clk);
    check("pre_start", 0, mk(0, 0, 0, 0, 0, model_sw, cnt0));
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = (i == stop_idx);
      if (noise != 0 && exp_q[i].busy) begin
        lo       = 4'($urandom_range(0, 15));
        hi       = 4'($urandom_range(0, 15));
        dwell    = 4'($urandom_range(0, 15));
        n_sweeps = 4'($urandom_range(0, 15));
        start    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("job", i, exp_q[i]);
      if (busy === 1'b1) busy_cycles++;
      if (i == rst_idx) begin
        #2 rst_n = 1'b0;
        #1 check("async_rst", i, mk(0, 0, 0, 0, 0, 0, int'(exp_q[i].cnt)));
        model_sw  = 0;
        model_cnt = int'(exp_q[i].cnt);
        break;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    sw_final = int'(sweeps);
    if (rst_idx < 0) begin
      model_sw  = int'(exp_q[exp_q.size()-1].sw);
      model_cnt = int'(exp_q[exp_q.size()-1].cnt);
    end
  endtask

  // A start with lo >= hi is rejected: one err pulse, nothing else moves
  task automatic run_err(int lo_i, int hi_i);
    @(posedge clk); #1;
    start = 1'b1; lo = lo_i[3:0]; hi = hi_i[3:0];
    @(negedge clk);
    check("err_req", lo_i, mk(0, 0, 0, 0, 0, model_sw, model_cnt));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", lo_i, mk(0, 0, 0, 0, 1, model_sw, model_cnt));
    @(posedge clk); #1;
    @(negedge clk);
    check("err_clear", lo_i, mk(0, 0, 0, 0, 0, model_sw, model_cnt));
  endtask

  initial begin
    int bc;
    int sw;
    int sidx;
    int c0, l, h, d, n, L;

    tv[0] = '{0,  2,  5,  1, 1, 0, 0, 11, 1};
    tv[1] = '{9,  3,  6,  0, 2, 0, 0, 22, 2};
    tv[2] = '{0,  0,  1,  0, 1, 0, 0,  4, 1};
    tv[3] = '{15, 14, 15, 15, 1, 0, 0, 20, 1};
    tv[4] = '{0,  0,  15, 0, 0, 3, 0, 97, 3};
    tv[5] = '{0,  2,  5,  1, 1, 0, 1, 11, 1};
    tv[6] = '{5,  4,  7,  2, 3, 0, 1, 35, 3};

    n_vec = 0; n_mis = 0; model_sw = 0; model_cnt = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    lo = '0; hi = '0; dwell = '0; n_sweeps = '0;
    ld = 1'b1; ldv = '0;
    @(negedge clk);
    check("reset", 0, mk(0, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1 ld = 1'b0;

    foreach (tv[t]) begin
      sidx = -1;
      if (tv[t].stop_sw != 0) begin
        build(tv[t].cnt0, tv[t].lo, tv[t].hi, tv[t].dw, tv[t].n, -1);
        foreach (exp_q[i]) if (sidx < 0 && int'(exp_q[i].sw) == tv[t].stop_sw) sidx = i;
      end
      run_job(tv[t].cnt0, tv[t].lo, tv[t].hi, tv[t].dw, tv[t].n, sidx, tv[t].noise, -1, bc, sw);
      check_int($sformatf("table%0d_busy_cycles", t), bc, tv[t].exp_len);
      check_int($sformatf("table%0d_sweeps", t), sw, tv[t].exp_sw);
    end

    run_err(7, 7);
    run_err(9, 3);

    // Reset asserted in the first DOWN cycle, then a normal job afterwards
    run_job(0, 2, 5, 1, 1, -1, 0, 8, bc, sw);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(tv[0].cnt0, tv[0].lo, tv[0].hi, tv[0].dw, tv[0].n, -1, 0, -1, bc, sw);
    check_int("post_reset_busy_cycles", bc, tv[0].exp_len);
    check_int("post_reset_sweeps", sw, tv[0].exp_sw);

    for (int r = 0; r < 30; r++) begin
      c0 = $urandom_range(0, 15);
      l  = $urandom_range(0, 14);
      h  = $urandom_range(l + 1, 15);
      d  = $urandom_range(0, 3);
      n  = $urandom_range(1, 3);
      sidx = -1;
      if ($urandom_range(0, 2) == 0) begin
        build(c0, l, h, d, n, -1);
        L = exp_q.size();
        sidx = $urandom_range(0, L - 3);
      end
      run_job(c0, l, h, d, n, sidx, $urandom_range(0, 1), -1, bc, sw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
